// File: rtl/imem_port_ctrl_if.sv
// Bus bundle between the instruction-RAM port controller and its clients:
// fetch requester, boot loader and the byte-wide synchronous RAM.
interface imem_port_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              boot;
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_valid;
  logic [31:0]       f_rdata;
  logic              f_err;
  logic              l_req;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0]        l_wdata;
  logic              l_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  // Controller side: serves requests, drives the RAM port.
  modport slave (
    input  boot, f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_valid, f_rdata, f_err, l_ack, mem_addr, mem_we, mem_wdata, busy
  );

  // Environment side: requesters plus RAM.
  modport master (
    output boot, f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    input  f_valid, f_rdata, f_err, l_ack, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_port_ctrl.sv
// Instruction-RAM port sequencer: splits 32-bit fetches into four byte reads,
// serves boot-loader byte writes, and round-robins the single RAM port.
module imem_port_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  imem_port_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cnt;
  logic [1:0]        cap;
  logic              last_fetch;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        byte0;
  logic [7:0]        byte1;
  logic [7:0]        byte2;
  logic              grant_f;
  logic              grant_l;
  logic              addr_ok;
  logic              capture;

  // Word-aligned and all four bytes inside the RAM.
  function automatic logic fetch_in_range(input logic [31:0] a);
    logic [32:0] lim;
    lim = (33'd1 << ADDR_W) - 33'd4;
    return (a[1:0] == 2'b00) && ({1'b0, a} <= lim);
  endfunction

  assign addr_ok = fetch_in_range(bus.f_addr);

  // Read data for address base+k arrives one cycle after it was driven.
  assign capture = ((state == FETCH) && (cnt != 2'd0)) || (state == WAIT);

  always_comb begin
    grant_f = 1'b0;
    grant_l = 1'b0;
    if (state == IDLE) begin
      if (bus.boot) begin
        grant_l = bus.l_req;
      end else if (bus.f_req && bus.l_req) begin
        grant_f = !last_fetch;
        grant_l = last_fetch;
      end else begin
        grant_f = bus.f_req;
        grant_l = bus.l_req;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_f) begin
          state_nxt = addr_ok ? FETCH : RESP;
        end else if (grant_l) begin
          state_nxt = WRITE;
        end
      end
      FETCH:   if (cnt == 2'd3) state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers and the response word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 2'd0;
      cap        <= 2'd0;
      last_fetch <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
    end else begin
      if (grant_f) begin
        last_fetch <= 1'b1;
        cnt        <= 2'd0;
        cap        <= 2'd0;
        err        <= !addr_ok;
        if (!addr_ok) rdata <= '0;
      end else if (grant_l) begin
        last_fetch <= 1'b0;
      end
      if (state == FETCH) cnt <= cnt + 2'd1;
      if (capture) cap <= cap + 2'd1;
      if (state == WAIT) rdata <= {bus.mem_rdata, byte2, byte1, byte0};
    end
  end

  // Request latches and byte lanes carry no reset; they are only observed
  // in the states that loaded them.
  always_ff @(posedge clk) begin
    if (grant_f) base <= bus.f_addr[ADDR_W-1:0];
    if (grant_l) begin
      wr_addr <= bus.l_addr;
      wr_data <= bus.l_wdata;
    end
    if ((state == FETCH) && (cnt != 2'd0)) begin
      case (cap)
        2'd0:    byte0 <= bus.mem_rdata;
        2'd1:    byte1 <= bus.mem_rdata;
        default: byte2 <= bus.mem_rdata;
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.f_valid   = (state == RESP);
    bus.f_err     = (state == RESP) && err;
    bus.l_ack     = (state == WRITE);
    bus.busy      = (state != IDLE);
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state)
      FETCH: bus.mem_addr = base + ADDR_W'(cnt);
      WRITE: begin
        bus.mem_addr  = wr_addr;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = wr_data;
      end
      default: ;
    endcase
  end

  assign bus.f_rdata = rdata;

endmodule

// File: doc/imem_port_ctrl.md
# imem_port_ctrl

Sequencer and arbiter for the byte-wide, single-port instruction RAM. It serves two requesters:
- the fetch stage, which reads 32-bit little-endian instruction words;
- the boot loader, which writes program bytes.

It turns each fetch into four byte reads, assembles the word, and grants the RAM port between fetch and loader. It sits between IF and the instruction RAM.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of the instruction RAM (RAM holds 2^ADDR_W bytes)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- boot  in  1  1 = loader-only mode; fetch requests are not granted
- f_req  in  1  fetch request; held until f_valid is seen
- f_addr  in  32  fetch byte address; stable while f_req=1
- f_valid  out  1  one-cycle response pulse
- f_rdata  out  32  assembled word {b[a+3],b[a+2],b[a+1],b[a+0]}; holds until next response
- f_err  out  1  qualifies f_valid; misaligned or out-of-range fetch
- l_req  in  1  loader write request; held until l_ack is seen
- l_addr  in  ADDR_W  loader byte address
- l_wdata  in  8  loader byte
- l_ack  out  1  one-cycle write acknowledge
- mem_addr  out  ADDR_W  RAM byte address
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data; synchronous read, valid the cycle after the address cycle
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, FETCH, WAIT, RESP, WRITE. A 2-bit byte counter cnt and a 2-bit capture counter are used only in FETCH/WAIT.
- Arbitration (sampled in IDLE only):
  - boot=1: only l_req can be granted.
  - boot=0 and exactly one request: that request is granted.
  - boot=0 and both requests: round-robin on a last-grant flag, which is set to the grantee at each grant.
  - The last-grant flag resets to "loader", so fetch wins the first tie.
- Fetch grant (f_addr[1:0]==0 and f_addr ≤ 2^ADDR_W−4):
  - Latch base=f_addr[ADDR_W-1:0], cnt=0, go to FETCH.
  - FETCH: mem_addr=base+cnt, mem_we=0, cnt increments each cycle; after cnt=3, go to WAIT.
  - mem_rdata is captured into byte lane k one cycle after address base+k was driven.
  - WAIT: captures byte 3, then goes to RESP.
  - RESP: f_valid=1, f_err=0, then IDLE.
- Fetch error (misaligned or out-of-range):
  - Go directly to RESP with f_err=1 and f_rdata=0.
  - No RAM access.
- Loader grant:
  - Latch l_addr/l_wdata, go to WRITE.
  - WRITE: mem_we=1, mem_addr/mem_wdata = latched values, l_ack=1, then IDLE.
- Outside FETCH/WRITE: mem_addr=0, mem_we=0, mem_wdata=0.
- Address arithmetic: base+cnt is computed mod 2^ADDR_W. Wrap cannot occur because of the range check.
- boot changing mid-operation does not affect the operation in progress; it affects only the next IDLE arbitration.
- A request dropped before its response violates the protocol. The block still completes the operation, and the response pulse is still issued.
- Reset (any time, asynchronous):
  - FSM→IDLE, counters→0, last-grant→loader.
  - Outputs→0: f_valid, f_err, f_rdata, l_ack, mem_addr, mem_we, mem_wdata, busy.
  - An in-flight fetch is discarded with no response.
  - A WRITE cut by reset has mem_we forced low immediately.

## Timing
- Accepting edge E0 = the IDLE edge at which the grant is made.
- Fetch:
  - mem_addr = base+0..base+3 in the cycles after E0..E3.
  - Bytes are captured at E2..E5.
  - f_valid is high in the cycle after E5 (5-edge latency); FSM returns to IDLE at E6.
  - The earliest next grant is at E7.
- Error fetch: f_valid/f_err are high in the cycle after E0; IDLE at E1.
- Write:
  - mem_we and l_ack are high in the cycle after E0; the RAM commits at E1; IDLE at E1.
  - The next grant is at E2, so the peak load rate is one byte per 2 cycles.
- Requester rule: on seeing f_valid or l_ack, the requester deasserts or re-presents new values at the next edge. The block never samples a request on the edge that leaves RESP/WRITE, so a request is never double-accepted.
- busy=1 from the cycle after E0 up to and including the RESP/WRITE cycle.

## Test plan
- Reset, then loader write sequence:
  - Stimulus: boot=1, write bytes d3,07,23,00 to addresses 0..3, then 13,01,60,01 to addresses 4..7.
  - Each l_ack arrives 1 cycle after its grant, at 2-cycle spacing, and mem_we pulses exactly 8 times.
  - Then boot=0, fetch at 0 → f_rdata=0x002307d3, f_err=0, f_valid 5 edges after the grant.
  - Then fetch at 4 → 0x01600113.
- Misaligned fetch:
  - Stimulus: fetch at 0x2.
  - Response: f_valid+f_err in the cycle after the grant, f_rdata=0, mem_addr stays 0 throughout.
- Out-of-range fetch (ADDR_W=8):
  - Fetch at 0xFC succeeds.
  - Fetch at 0x100 → f_err=1.
- Arbitration:
  - Stimulus: boot=0, f_req and l_req both held continuously.
  - Grants alternate fetch, loader, fetch, loader, with fetch first after reset.
  - Under boot=1, a pending f_req receives no f_valid until boot drops.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 during the third FETCH cycle.
  - Response: all outputs 0 immediately and no f_valid.
  - After release, a re-issued fetch at 0 returns 0x002307d3.
